// File: rtl/cache_bus_pkg.sv
// Shared types and helpers for the cache bus memory responder.
// Holds the FSM encoding, bus widths and the wrap-burst mask helper.
package cache_bus_pkg;

  localparam int BL_W   = 4;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_BURST,
    ST_WR_BURST,
    ST_WR_RESP
  } state_e;

  // Mask of the in-block offset bits for a wrap burst of len+1 beats.
  // Returns zero when len+1 is not a power of two.
  function automatic logic [BL_W-1:0] wrap_mask(
    input logic [BL_W-1:0] len
  );
    logic [BL_W:0] beats;
    beats = {1'b0, len} + 1'b1;
    if (({1'b0, len} & beats) == '0) begin
      return len;
    end
    return '0;
  endfunction

endpackage

// File: rtl/memresp_ram.sv
// Single-port synchronous RAM, one-cycle read, write-first.
// Contents are never reset.
module memresp_ram
  import cache_bus_pkg::*;
#(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
      rdata_o     <= wdata_i;
    end else begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/cache_bus_mem_responder.sv
// Memory-side responder for the cache bus: burst reads and writes.
// Define CACHE_RESP_WRAP_EN for wrap (critical-word-first) reads.
module cache_bus_mem_responder
  import cache_bus_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren_i,
  input  logic [31:0]       raddr_i,
  input  logic [BL_W-1:0]   rlen_i,
  input  logic              rready_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  input  logic              wen_i,
  input  logic [31:0]       waddr_i,
  input  logic [BL_W-1:0]   wlen_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              wvalid_i,
  input  logic              wlast_i,
  output logic              bvalid_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

  typedef logic [AW-1:0] idx_t;

  state_e          state_q, state_d;
  idx_t            idx_q, idx_d;
  logic [BL_W-1:0] len_q, len_d;
  logic [BL_W-1:0] beat_q, beat_d;
  logic [BL_W:0]   wcnt_q, wcnt_d;
  logic [3:0]      lat_q, lat_d;
  logic            wrap_q, wrap_d;
  logic            rvalid_q, rvalid_d;
  logic            bvalid_q, bvalid_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  idx_t              ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  idx_t              rd_idx;
  idx_t              wr_idx;
  idx_t              rd_next;
  idx_t              idx_inc;
  idx_t              wmask;

  logic unused_addr;
  assign unused_addr = ^{raddr_i[1:0], raddr_i[31:AW+2],
                         waddr_i[1:0], waddr_i[31:AW+2]};

  assign rd_idx  = raddr_i[AW+1:2];
  assign wr_idx  = waddr_i[AW+1:2];
  assign idx_inc = idx_q + idx_t'(1);
  assign wmask   = idx_t'(len_q);

  always_comb begin
    rd_next = idx_inc;
    if (wrap_q) begin
      rd_next = (idx_q & ~wmask) | (idx_inc & wmask);
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    beat_d   = beat_q;
    wcnt_d   = wcnt_q;
    lat_d    = lat_q;
    wrap_d   = wrap_q;
    rvalid_d = rvalid_q;
    bvalid_d = 1'b0;
    err_d    = err_q;
    ram_we   = 1'b0;
    ram_addr = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        // Reading ahead here lets RD_LAT=1 present data next cycle.
        ram_addr = rd_idx;
        if (wen_i) begin
          idx_d   = wr_idx;
          len_d   = wlen_i;
          wcnt_d  = '0;
          state_d = ST_WR_BURST;
        end else if (ren_i) begin
          idx_d  = rd_idx;
          len_d  = rlen_i;
          beat_d = '0;
          lat_d  = LAT_M1;
          wrap_d = 1'b0;
`ifdef CACHE_RESP_WRAP_EN
          if (wrap_mask(rlen_i) == rlen_i) begin
            wrap_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
`endif
          if (RD_LAT == 1) begin
            state_d  = ST_RD_BURST;
            rvalid_d = 1'b1;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          state_d  = ST_RD_BURST;
          rvalid_d = 1'b1;
        end
      end
      ST_RD_BURST: begin
        if (rready_i) begin
          if (beat_q == len_q) begin
            state_d  = ST_IDLE;
            rvalid_d = 1'b0;
          end else begin
            beat_d   = beat_q + 4'd1;
            idx_d    = rd_next;
            ram_addr = rd_next;
          end
        end
      end
      ST_WR_BURST: begin
        if (wvalid_i) begin
          if (wcnt_q <= {1'b0, len_q}) begin
            ram_we = 1'b1;
            idx_d  = idx_inc;
            wcnt_d = wcnt_q + 5'd1;
          end else begin
            err_d = 1'b1;
          end
          if (wlast_i) begin
            if (wcnt_q < {1'b0, len_q}) begin
              err_d = 1'b1;
            end
            state_d  = ST_WR_RESP;
            bvalid_d = 1'b1;
          end
        end
      end
      ST_WR_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        rvalid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      wcnt_q   <= '0;
      lat_q    <= '0;
      wrap_q   <= 1'b0;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      wcnt_q   <= wcnt_d;
      lat_q    <= lat_d;
      wrap_q   <= wrap_d;
      rvalid_q <= rvalid_d;
      bvalid_q <= bvalid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  memresp_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_i),
    .rdata_o (ram_rdata)
  );

  assign rdata_o  = rvalid_q ? ram_rdata : '0;
  assign rvalid_o = rvalid_q;
  assign bvalid_o = bvalid_q;
  assign busy_o   = busy_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_cache_bus_mem_responder.sv
// Directed bench for cache_bus_mem_responder with a read scoreboard.
// Expected read data comes from a bench-side memory model.
module tb_cache_bus_mem_responder;

  localparam int MEM_WORDS = 4096;
  localparam int RD_LAT    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren_i;
  logic [31:0] raddr_i;
  logic [3:0]  rlen_i;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        wen_i;
  logic [31:0] waddr_i;
  logic [3:0]  wlen_i;
  logic [31:0] wdata_i;
  logic        wvalid_i;
  logic        wlast_i;
  logic        bvalid_o;
  logic        busy_o;
  logic        err_o;

  int tests = 0;
  int fails = 0;
  logic        err_exp = 1'b0;
  logic [31:0] model [MEM_WORDS];
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  cache_bus_mem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ren_i    (ren_i),
    .raddr_i  (raddr_i),
    .rlen_i   (rlen_i),
    .rready_i (rready_i),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o),
    .wen_i    (wen_i),
    .waddr_i  (waddr_i),
    .wlen_i   (wlen_i),
    .wdata_i  (wdata_i),
    .wvalid_i (wvalid_i),
    .wlast_i  (wlast_i),
    .bvalid_o (bvalid_o),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a, input int k,
                              input int len);
    int s;
    s = int'((a >> 2) & (MEM_WORDS - 1));
`ifdef CACHE_RESP_WRAP_EN
    if ((((len + 1) & len)) == 0) return (s & ~len) | ((s + k) & len);
`endif
    return (s + k) % MEM_WORDS;
  endfunction

  always @(negedge clk) begin
    if (!rst && rvalid_o && rready_i) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL rd_extra: observed beat %h expected none", rdata_o);
      end
      if (sb.size() != 0) chk("rd_data", rdata_o, sb.pop_front());
    end
  end

  task automatic do_write(input logic [31:0] addr, input int len,
                          input int n, input logic [31:0] d0,
                          input logic [31:0] step);
    #1;
    wen_i = 1'b1; waddr_i = addr; wlen_i = 4'(len);
    @(posedge clk); #1;
    wen_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      wvalid_i = 1'b1;
      wdata_i  = d0 + step * i;
      wlast_i  = (i == n - 1);
      if (i <= len) model[widx(addr, i, 0) % MEM_WORDS] = wdata_i;
      if (i == 0) chk("wr_busy", busy_o, 1'b1);
      @(posedge clk); #1;
    end
    wvalid_i = 1'b0; wlast_i = 1'b0;
    if (n != len + 1) err_exp = 1'b1;
    @(negedge clk);
    chk("wr_bvalid", bvalid_o, 1'b1);
    chk("wr_err", err_o, err_exp);
    @(negedge clk);
    chk("wr_bvalid_pulse", bvalid_o, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len,
                         input int s, input int c);
    logic [31:0] e [$];
    int cyc, got, first;
    #1;
    for (int k = 0; k <= len; k++) begin
      e.push_back(model[widx(addr, k, len)]);
      sb.push_back(model[widx(addr, k, len)]);
    end
`ifdef CACHE_RESP_WRAP_EN
    if (((len + 1) & len) != 0) err_exp = 1'b1;
`endif
    ren_i = 1'b1; raddr_i = addr; rlen_i = 4'(len); rready_i = 1'b1;
    @(posedge clk); #1;
    ren_i = 1'b0;
    cyc = 1; got = 0; first = 0;
    while (got < len + 1 && cyc < 64) begin
      rready_i = !(c > 0 && cyc >= RD_LAT + s && cyc < RD_LAT + s + c);
      @(negedge clk);
      if (cyc == 1) chk("rd_busy", busy_o, 1'b1);
      if (rvalid_o && first == 0) begin
        first = cyc;
        chk("rd_latency", first, RD_LAT);
      end
      if (!rready_i) begin
        chk("rd_hold_valid", rvalid_o, 1'b1);
        chk("rd_hold_data", rdata_o, e[got]);
      end
      if (rvalid_o && rready_i) got++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rd_beats", got, len + 1);
    if (got != len + 1) sb.delete();
    chk("rd_throughput", cyc, RD_LAT + len + 1 + c);
    rready_i = 1'b0;
    @(negedge clk);
    chk("rd_valid_drop", rvalid_o, 1'b0);
    chk("rd_sb_empty", sb.size(), 0);
    chk("rd_err", err_o, err_exp);
  endtask

  task automatic pulse_rst();
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    chk("rst_rvalid", rvalid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ren_i = 1'b0; raddr_i = '0; rlen_i = '0; rready_i = 1'b0;
    wen_i = 1'b0; waddr_i = '0; wlen_i = '0; wdata_i = '0;
    wvalid_i = 1'b0; wlast_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_rvalid", rvalid_o, 1'b0);
    chk("reset_bvalid", bvalid_o, 1'b0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_err", err_o, 1'b0);

    do_write(32'h100, 3, 4, 32'h11, 32'h11);
    do_read(32'h100, 3, 0, 0);
    do_read(32'h100, 3, 1, 3);

    do_write(32'h110, 1, 2, 32'hF0, 32'h1);
    do_write(32'h200, 1, 2, 32'h55, 32'h1);
    do_write(32'h300, 3, 4, 32'hA0, 32'h1);

    // Write and read together: write first, read picked up after.
    #1;
    ren_i = 1'b1; raddr_i = 32'h200; rlen_i = 4'd1; rready_i = 1'b1;
    do_write(32'h200, 1, 2, 32'hB0, 32'h1);
    chk("wr_first_no_rvalid", rvalid_o, 1'b0);
    do_read(32'h200, 1, 0, 0);

    do_write(32'h300, 1, 3, 32'hC0, 32'h1);
    do_read(32'h300, 2, 0, 0);
    chk("err_sticky", err_o, 1'b1);

    #1;
    ren_i = 1'b1; raddr_i = 32'h100; rlen_i = 4'd3; rready_i = 1'b0;
    @(posedge clk); #1;
    ren_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrd_rvalid", rvalid_o, 1'b1);
    pulse_rst();
    chk("midrd_rdata", rdata_o, 32'h0);

    do_read(32'h300, 1, 0, 0);

    do_write(32'h400, 3, 2, 32'hD0, 32'h1);
    pulse_rst();

    do_read(32'h108, 3, 0, 0);

    do_write(32'h3FF8, 3, 4, 32'hE0, 32'h1);
    do_read(32'h3FFC, 1, 0, 0);
    do_read(32'h4000, 0, 0, 0);

`ifdef CACHE_RESP_WRAP_EN
    do_read(32'h100, 2, 0, 0);
    chk("wrap_npow2_err", err_o, 1'b1);
    pulse_rst();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
